// File: rtl/elevator_pkg.sv
// Shared codes and status encodings for the elevator display path.
//   CODE_*      : 4-bit glyph codes fed to the BCD_7SEG decoder
//   status_e    : status FSM state encoding (IDLE=0, ENTER=1, HELP=2)
//   floor_code_sanitize : maps an incoming floor code to a displayable code
package elevator_pkg;

  localparam logic [3:0] CODE_FLOOR0 = 4'h0;
  localparam logic [3:0] CODE_FLOOR1 = 4'h1;
  localparam logic [3:0] CODE_HELP   = 4'h2;
  localparam logic [3:0] CODE_ENTER  = 4'h3;
  localparam logic [3:0] CODE_BLANK  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTER = 2'd1,
    ST_HELP  = 2'd2
  } status_e;

  // Only floors 0 and 1 exist; anything else is shown blank.
  function automatic logic [3:0] floor_code_sanitize(input logic [3:0] code);
    return (code <= CODE_FLOOR1) ? code : CODE_BLANK;
  endfunction

endpackage

// File: rtl/elevator_display_ctrl_bcd_7seg.sv
// BCD_7SEG: shared glyph decoder for the elevator display.
//   bcd [3:0] in  : glyph code (see elevator_pkg)
//   seg [6:0] out : segment pattern, bit 6 = a ... bit 0 = g, active-high
// Floor codes 0/1 are shown as the digits "1"/"2"; HELP and ENTER reuse the
// "3"/"4" patterns; every other code is blank.
module BCD_7SEG
  import elevator_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = '0;
    unique case (bcd)
      CODE_FLOOR0: seg = 7'b0110000;
      CODE_FLOOR1: seg = 7'b1101101;
      CODE_HELP:   seg = 7'b1111001;
      CODE_ENTER:  seg = 7'b0110011;
      default:     seg = '0;
    endcase
  end

endmodule

// File: rtl/elevator_display_ctrl.sv
// elevator_display_ctrl: scan scheduler for the 2-digit elevator display.
// One BCD_7SEG decoder is time-shared between both digits; digit 0 shows the
// current floor, digit 1 shows the status glyph (blinking Help, held Enter,
// or blank).
//   clk, rst_n   : clock, asynchronous active-low reset
//   floor_code   : floor code, captured on floor_load (only 0/1 valid)
//   floor_load   : 1-cycle capture strobe for floor_code
//   help_req     : level, Help request (highest priority)
//   enter_pulse  : 1-cycle strobe requesting the Enter glyph
//   seg          : registered segment pattern for the enabled digit
//   digit_en     : registered one-hot digit enable
//   status_st    : status FSM state (IDLE=0, ENTER=1, HELP=2)
module elevator_display_ctrl
  import elevator_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned BLINK_DIV  = 64,
  parameter int unsigned ENTER_HOLD = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] floor_code,
  input  logic       floor_load,
  input  logic       help_req,
  input  logic       enter_pulse,
  output logic [6:0] seg,
  output logic [1:0] digit_en,
  output logic [1:0] status_st
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam int unsigned BW = $clog2(BLINK_DIV + 1);
  localparam int unsigned HW = $clog2(ENTER_HOLD + 1);

  localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(ENTER_HOLD);
  localparam logic [HW-1:0] HOLD_ONE   = HW'(1);

  logic [PW-1:0] prescaler;
  logic          scan_tick;
  logic [3:0]    floor_q;
  status_e       st;
  logic [BW-1:0] blink_cnt;
  logic          blink_ph;
  logic [HW-1:0] hold_cnt;

  logic          next_is_d1;
  logic [3:0]    d1_code;
  logic [3:0]    next_code;
  logic [6:0]    seg_next;

  assign scan_tick = (prescaler == PRE_LAST);
  assign status_st = st;

  // The mux selects the digit that is about to be enabled, so the decoded
  // pattern lands in seg on the same edge that moves digit_en.
  always_comb begin
    next_is_d1 = (digit_en == 2'b01);
    d1_code    = CODE_BLANK;
    unique case (st)
      ST_ENTER: d1_code = CODE_ENTER;
      ST_HELP:  d1_code = blink_ph ? CODE_HELP : CODE_BLANK;
      default:  d1_code = CODE_BLANK;
    endcase
    next_code = next_is_d1 ? d1_code : floor_q;
  end

  BCD_7SEG u_dec (
    .bcd (next_code),
    .seg (seg_next)
  );

  // Prescaler, digit scan and floor capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      digit_en  <= 2'b00;
      seg       <= '0;
      floor_q   <= CODE_BLANK;
    end else begin
      prescaler <= scan_tick ? '0 : prescaler + PW'(1);
      if (scan_tick) begin
        digit_en <= next_is_d1 ? 2'b10 : 2'b01;
        seg      <= seg_next;
      end
      if (floor_load) begin
        floor_q <= floor_code_sanitize(floor_code);
      end
    end
  end

  // Status FSM with its blink and hold counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ST_IDLE;
      blink_cnt <= '0;
      blink_ph  <= 1'b1;
      hold_cnt  <= '0;
    end else if (help_req) begin
      st       <= ST_HELP;
      hold_cnt <= '0;
      if (st != ST_HELP) begin
        blink_ph  <= 1'b1;
        blink_cnt <= '0;
      end else if (scan_tick) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          blink_ph  <= ~blink_ph;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end else begin
      unique case (st)
        ST_HELP: begin
          // Leaving HELP restores the blink state; a pending Enter is dropped.
          st        <= ST_IDLE;
          blink_cnt <= '0;
          blink_ph  <= 1'b1;
        end
        ST_IDLE: begin
          if (enter_pulse) begin
            st       <= ST_ENTER;
            hold_cnt <= HOLD_LOAD;
          end
        end
        ST_ENTER: begin
          if (enter_pulse) begin
            hold_cnt <= HOLD_LOAD;
          end else if (scan_tick) begin
            if (hold_cnt == HOLD_ONE) begin
              st       <= ST_IDLE;
              hold_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt - HW'(1);
            end
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_display_ctrl.sv
// Self-checking bench for elevator_display_ctrl (SCAN_DIV=4, BLINK_DIV=2,
// ENTER_HOLD=3). A behavioural reference model predicts the outputs after
// every clock edge; predictions are queued when stimulus is driven and
// checked once the edge has happened. Directed checks add fixed expectations.
module tb_elevator_display_ctrl;

  localparam int SD = 4;
  localparam int BD = 2;
  localparam int EH = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] floor_code = '0;
  logic       floor_load = 1'b0;
  logic       help_req = 1'b0;
  logic       enter_pulse = 1'b0;
  logic [6:0] seg;
  logic [1:0] digit_en;
  logic [1:0] status_st;

  int compared = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [6:0] seg;
    logic [1:0] den;
    logic [1:0] st;
  } exp_t;

  exp_t sb[$];

  // reference model state
  int         m_pre;
  logic [1:0] m_den;
  logic [6:0] m_seg;
  int         m_st;     // 0 idle, 1 enter, 2 help
  logic [3:0] m_floor;
  int         m_bcnt;
  bit         m_bph;
  int         m_hold;
  bit         m_tick;

  elevator_display_ctrl #(
    .SCAN_DIV   (SD),
    .BLINK_DIV  (BD),
    .ENTER_HOLD (EH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .floor_code  (floor_code),
    .floor_load  (floor_load),
    .help_req    (help_req),
    .enter_pulse (enter_pulse),
    .seg         (seg),
    .digit_en    (digit_en),
    .status_st   (status_st)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] c);
    case (c)
      4'h0:    return 7'b0110000;
      4'h1:    return 7'b1101101;
      4'h2:    return 7'b1111001;
      4'h3:    return 7'b0110011;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic model_reset();
    m_pre = 0; m_den = 2'b00; m_seg = '0; m_st = 0; m_floor = 4'hF;
    m_bcnt = 0; m_bph = 1; m_hold = 0; m_tick = 0;
  endtask

  task automatic model_edge(input bit h, input bit e, input bit fl, input logic [3:0] fc);
    logic [3:0] c;
    int st0;
    st0 = m_st;
    m_tick = (m_pre == SD - 1);
    if (m_tick) begin
      if (m_den == 2'b01) begin
        c = (st0 == 1) ? 4'h3 : (st0 == 2 && m_bph) ? 4'h2 : 4'hF;
        m_den = 2'b10;
      end else begin
        c = m_floor;
        m_den = 2'b01;
      end
      m_seg = glyph(c);
      m_pre = 0;
    end else begin
      m_pre = m_pre + 1;
    end
    if (fl) m_floor = (fc < 2) ? fc : 4'hF;
    if (h) begin
      m_hold = 0;
      if (st0 != 2) begin
        m_bph = 1; m_bcnt = 0;
      end else if (m_tick) begin
        m_bcnt = m_bcnt + 1;
        if (m_bcnt == BD) begin m_bcnt = 0; m_bph = !m_bph; end
      end
      m_st = 2;
    end else if (st0 == 2) begin
      m_st = 0; m_bcnt = 0; m_bph = 1;
    end else if (e) begin
      m_st = 1; m_hold = EH;
    end else if (st0 == 1 && m_tick) begin
      m_hold = m_hold - 1;
      if (m_hold == 0) m_st = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // Drive one cycle of stimulus, predict the result, let the edge happen,
  // then compare the oldest prediction with the DUT.
  task automatic step(input bit h, input bit e, input bit fl, input logic [3:0] fc);
    exp_t x;
    help_req = h; enter_pulse = e; floor_load = fl; floor_code = fc;
    model_edge(h, e, fl, fc);
    sb.push_back('{seg: m_seg, den: m_den, st: 2'(m_st)});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("seg", seg, x.seg);
    chk("digit_en", 7'(digit_en), 7'(x.den));
    chk("status_st", 7'(status_st), 7'(x.st));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 4'h0);
  endtask

  initial begin
    bit found;
    model_reset();
    #12;
    chk("reset_seg", seg, 7'b0000000);
    chk("reset_den", 7'(digit_en), 7'b0000000);
    chk("reset_st", 7'(status_st), 7'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: blank scan, ticks at cycles 3 and 7
    run(4);
    chk("t1_den_first", 7'(digit_en), 7'b01);
    run(4);
    chk("t1_den_second", 7'(digit_en), 7'b10);
    chk("t1_seg_blank", seg, 7'b0000000);

    // 2: floor load, seen on next digit-0 refresh
    step(0, 0, 1, 4'h1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 0, 0, 4'h0);
      if (m_tick && m_den == 2'b01) found = 1;
    end
    chk("t2_refresh_seen", 7'(found), 7'd1);
    chk("t2_floor1_seg", seg, 7'b1101101);
    step(0, 0, 1, 4'h5);
    run(8);

    // 3: enter, hold and retrigger
    step(0, 1, 0, 4'h0);
    chk("t3_enter_st", 7'(status_st), 7'd1);
    run(8);
    chk("t3_still_enter", 7'(status_st), 7'd1);
    run(4);
    chk("t3_back_idle", 7'(status_st), 7'd0);
    step(0, 1, 0, 4'h0);
    run(8);
    step(0, 1, 0, 4'h0);
    run(8);
    chk("t3_retrig_held", 7'(status_st), 7'd1);
    run(4);
    chk("t3_retrig_done", 7'(status_st), 7'd0);

    // 4: help blink and release
    step(1, 0, 0, 4'h0);
    chk("t4_help_st", 7'(status_st), 7'd2);
    for (int i = 0; i < 40; i++) step(1, 0, 0, 4'h0);
    step(0, 0, 0, 4'h0);
    chk("t4_help_drop", 7'(status_st), 7'd0);
    run(8);

    // 5: help beats enter; enter in help is dropped
    step(1, 1, 0, 4'h0);
    chk("t5_help_wins", 7'(status_st), 7'd2);
    step(1, 1, 0, 4'h0);
    step(1, 0, 0, 4'h0);
    step(0, 0, 0, 4'h0);
    chk("t5_no_enter", 7'(status_st), 7'd0);
    run(8);
    chk("t5_still_idle", 7'(status_st), 7'd0);

    // 6: asynchronous reset mid-ENTER, between edges
    step(0, 1, 0, 4'h0);
    run(5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_seg", seg, 7'b0000000);
    chk("t6_rst_den", 7'(digit_en), 7'b0000000);
    chk("t6_rst_st", 7'(status_st), 7'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run(4);
    chk("t6_restart_d0", 7'(digit_en), 7'b01);
    run(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
